// File: rtl/frame_link_ctrl.sv
// Link supervisor for the 56-bit frame synchronizer: sequences IDLE/ACQUIRE/LOCKED/RECOVER,
// gates the receive path and keeps saturating link statistics.
module frame_link_ctrl #(
  parameter int unsigned LOCK_FRAMES = 4,
  parameter int unsigned UNLOCK_ERRS = 3,
  parameter int unsigned HOLD_CYCLES = 64,
  parameter int unsigned TIMEOUT     = 4096
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        data_valid,
  input  logic        frame_error,
  input  logic        sync_lost,
  input  logic        clear_stats,
  output logic        rx_enable,
  output logic        link_up,
  output logic [1:0]  link_state,
  output logic        resync_req,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt,
  output logic [7:0]  loss_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACQUIRE = 2'b01,
    LOCKED  = 2'b10,
    RECOVER = 2'b11
  } state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] WD_LAST   = 16'(TIMEOUT - 1);
  localparam logic [7:0]  RUN_LOCK  = 8'(LOCK_FRAMES);
  localparam logic [3:0]  BAD_LIMIT = 4'(UNLOCK_ERRS);

  state_t      state;
  logic [15:0] hold_cnt;
  logic [15:0] wd_cnt;
  logic [7:0]  run_cnt;
  logic [3:0]  bad_cnt;

  logic [7:0]  run_next;
  logic [3:0]  bad_next;
  logic        wd_expired;
  logic        locked_loss;
  logic        loss_event;

  // A data_valid in the expiry cycle rescues the link; a coincident sync_lost still counts as a loss.
  always_comb begin
    wd_expired = (wd_cnt == WD_LAST) && !data_valid;

    run_next = run_cnt;
    if (frame_error || sync_lost) run_next = '0;
    else if (data_valid)          run_next = run_cnt + 8'd1;

    bad_next = bad_cnt;
    if (frame_error)     bad_next = bad_cnt + 4'd1;
    else if (data_valid) bad_next = '0;

    locked_loss = sync_lost || (bad_next == BAD_LIMIT) || wd_expired;
    loss_event  = (state == LOCKED) && locked_loss;
  end

  assign link_state = state;

  // NOTE: every register below is assigned with <= so all branches see the pre-edge values.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      rx_enable  <= 1'b0;
      link_up    <= 1'b0;
      resync_req <= 1'b0;
      hold_cnt   <= '0;
      wd_cnt     <= '0;
      run_cnt    <= '0;
      bad_cnt    <= '0;
    end else begin
      resync_req <= 1'b0;
      case (state)
        IDLE, RECOVER: begin
          if (hold_cnt == HOLD_LAST) begin
            state     <= ACQUIRE;
            rx_enable <= 1'b1;
            hold_cnt  <= '0;
            wd_cnt    <= '0;
            run_cnt   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        ACQUIRE: begin
          if (run_next == RUN_LOCK) begin
            state   <= LOCKED;
            link_up <= 1'b1;
            run_cnt <= '0;
            bad_cnt <= '0;
            wd_cnt  <= '0;
          end else if (wd_expired) begin
            state      <= RECOVER;
            rx_enable  <= 1'b0;
            resync_req <= 1'b1;
            run_cnt    <= '0;
            wd_cnt     <= '0;
            hold_cnt   <= '0;
          end else begin
            run_cnt <= run_next;
            wd_cnt  <= data_valid ? 16'd0 : wd_cnt + 16'd1;
          end
        end
        LOCKED: begin
          if (locked_loss) begin
            state      <= RECOVER;
            rx_enable  <= 1'b0;
            link_up    <= 1'b0;
            resync_req <= 1'b1;
            bad_cnt    <= '0;
            wd_cnt     <= '0;
            hold_cnt   <= '0;
          end else begin
            bad_cnt <= bad_next;
            wd_cnt  <= data_valid ? 16'd0 : wd_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics run in every state; clear_stats beats any coincident increment.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      good_cnt <= '0;
      err_cnt  <= '0;
      loss_cnt <= '0;
    end else if (clear_stats) begin
      good_cnt <= '0;
      err_cnt  <= '0;
      loss_cnt <= '0;
    end else begin
      if (data_valid && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
      if (frame_error && (err_cnt != 16'hFFFF)) err_cnt  <= err_cnt + 16'd1;
      if (loss_event && (loss_cnt != 8'hFF))    loss_cnt <= loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_link_ctrl.sv
// Directed and randomized bench for frame_link_ctrl against a cycle-level behavioural model
// that tracks phase durations, quiet time and frame runs as plain integers.
module tb_frame_link_ctrl;

  localparam int HOLD   = 64;
  localparam int LOCK   = 4;
  localparam int UNLOCK = 3;
  localparam int TMO    = 4096;

  localparam int M_IDLE    = 0;
  localparam int M_ACQ     = 1;
  localparam int M_LOCKED  = 2;
  localparam int M_RECOVER = 3;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid = 1'b0;
  logic        frame_error = 1'b0;
  logic        sync_lost = 1'b0;
  logic        clear_stats = 1'b0;
  logic        rx_enable;
  logic        link_up;
  logic [1:0]  link_state;
  logic        resync_req;
  logic [15:0] good_cnt;
  logic [15:0] err_cnt;
  logic [7:0]  loss_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: phase position, quiet time since last frame, clean-run and error-run lengths.
  int m_phase;
  int m_in_phase;
  int m_quiet;
  int m_clean;
  int m_errs;
  int m_good;
  int m_err;
  int m_loss;
  bit m_resync;

  always #5 clk_sys = ~clk_sys;

  frame_link_ctrl #(
    .LOCK_FRAMES(LOCK),
    .UNLOCK_ERRS(UNLOCK),
    .HOLD_CYCLES(HOLD),
    .TIMEOUT(TMO)
  ) dut (
    .clk_sys(clk_sys),
    .rst_n(rst_n),
    .data_valid(data_valid),
    .frame_error(frame_error),
    .sync_lost(sync_lost),
    .clear_stats(clear_stats),
    .rx_enable(rx_enable),
    .link_up(link_up),
    .link_state(link_state),
    .resync_req(resync_req),
    .good_cnt(good_cnt),
    .err_cnt(err_cnt),
    .loss_cnt(loss_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_in_phase = 0;
    m_quiet = 0;
    m_clean = 0;
    m_errs = 0;
    m_good = 0;
    m_err = 0;
    m_loss = 0;
    m_resync = 0;
  endtask

  task automatic model_enter(input int next_phase);
    m_phase = next_phase;
    m_in_phase = 0;
    m_quiet = 0;
    m_clean = 0;
    m_errs = 0;
    m_resync = (next_phase == M_RECOVER);
  endtask

  task automatic model_step(input bit dv, input bit fe, input bit sl, input bit cs);
    bit lost_lock;
    lost_lock = 0;
    m_resync = 0;
    case (m_phase)
      M_IDLE, M_RECOVER: begin
        m_in_phase++;
        if (m_in_phase == HOLD) model_enter(M_ACQ);
      end
      M_ACQ: begin
        if (fe || sl) m_clean = 0;
        else if (dv)  m_clean++;
        m_quiet = dv ? 0 : m_quiet + 1;
        if (m_clean == LOCK)      model_enter(M_LOCKED);
        else if (m_quiet == TMO)  model_enter(M_RECOVER);
      end
      default: begin
        if (fe)      m_errs++;
        else if (dv) m_errs = 0;
        m_quiet = dv ? 0 : m_quiet + 1;
        if (sl || m_errs == UNLOCK || m_quiet == TMO) begin
          lost_lock = 1;
          model_enter(M_RECOVER);
        end
      end
    endcase
    if (cs) begin
      m_good = 0;
      m_err = 0;
      m_loss = 0;
    end else begin
      if (dv && m_good < 65535) m_good++;
      if (fe && m_err < 65535)  m_err++;
      if (lost_lock && m_loss < 255) m_loss++;
    end
  endtask

  task automatic compare_all();
    check("link_state", 32'(link_state), 32'(m_phase));
    check("rx_enable", 32'(rx_enable), 32'((m_phase == M_ACQ) || (m_phase == M_LOCKED)));
    check("link_up", 32'(link_up), 32'(m_phase == M_LOCKED));
    check("resync_req", 32'(resync_req), 32'(m_resync));
    check("good_cnt", 32'(good_cnt), 32'(m_good));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
    check("loss_cnt", 32'(loss_cnt), 32'(m_loss));
  endtask

  task automatic step(input bit dv, input bit fe, input bit sl, input bit cs);
    data_valid = dv;
    frame_error = fe;
    sync_lost = sl;
    clear_stats = cs;
    @(posedge clk_sys);
    #1;
    model_step(dv, fe, sl, cs);
    compare_all();
    data_valid = 0;
    frame_error = 0;
    sync_lost = 0;
    clear_stats = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  initial begin
    int r;
    bit dv;
    bit fe;
    bit sl;
    bit cs;

    // Reset state
    model_reset();
    #12;
    compare_all();
    @(negedge clk_sys);
    rst_n = 1'b1;

    // Hold in IDLE then acquire
    idle(HOLD - 1);
    check("idle_hold_rx", 32'(rx_enable), 32'd0);
    idle(1);
    check("acq_entry_state", 32'(link_state), 32'd1);
    check("acq_entry_rx", 32'(rx_enable), 32'd1);

    // Four clean frames 56 cycles apart lock the link
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0);
      if (i < 3) idle(55);
    end
    check("lock_state", 32'(link_state), 32'd2);
    check("lock_up", 32'(link_up), 32'd1);
    check("lock_good", 32'(good_cnt), 32'd4);

    // Three CRC errors drop to RECOVER
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      if (i < 2) idle(9);
    end
    check("unlock_state", 32'(link_state), 32'd3);
    check("unlock_resync", 32'(resync_req), 32'd1);
    check("unlock_loss", 32'(loss_cnt), 32'd1);
    idle(1);
    check("resync_one_cycle", 32'(resync_req), 32'd0);
    idle(HOLD - 2);
    check("recover_hold_rx", 32'(rx_enable), 32'd0);
    idle(1);
    check("recover_exit_state", 32'(link_state), 32'd1);

    // Error in the middle of the run restarts the count
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("no_early_lock", 32'(link_state), 32'd1);
      step(i != 3, i == 3, 0, 0);
      idle(4);
    end
    check("relock_state", 32'(link_state), 32'd2);
    check("relock_err", 32'(err_cnt), 32'd4);
    check("relock_good", 32'(good_cnt), 32'd11);

    // Coincident data_valid + sync_lost in LOCKED
    step(1, 0, 1, 0);
    check("dvsl_state", 32'(link_state), 32'd3);
    check("dvsl_good", 32'(good_cnt), 32'd12);
    check("dvsl_loss", 32'(loss_cnt), 32'd2);
    idle(HOLD);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    check("relock2_state", 32'(link_state), 32'd2);

    // Watchdog in LOCKED
    idle(TMO - 1);
    check("wd_locked_before", 32'(link_state), 32'd2);
    idle(1);
    check("wd_locked_fire", 32'(link_state), 32'd3);
    check("wd_locked_loss", 32'(loss_cnt), 32'd3);
    idle(HOLD);

    // Watchdog in ACQUIRE does not count as a loss
    idle(TMO - 1);
    check("wd_acq_before", 32'(link_state), 32'd1);
    idle(1);
    check("wd_acq_fire", 32'(link_state), 32'd3);
    check("wd_acq_loss", 32'(loss_cnt), 32'd3);
    idle(HOLD);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 255));
      dv = (r < 40);
      fe = !dv && (r >= 40) && (r < 48);
      sl = ($urandom_range(0, 199) == 0);
      cs = ($urandom_range(0, 499) == 0);
      step(dv, fe, sl, cs);
    end

    // Saturation of good_cnt, then clear beats a coincident pulse
    step(0, 0, 0, 1);
    check("clear_good", 32'(good_cnt), 32'd0);
    for (int i = 0; i < 65540; i++) step(1, 0, 0, 0);
    check("sat_good", 32'(good_cnt), 32'hFFFF);
    step(1, 0, 0, 1);
    check("clear_wins", 32'(good_cnt), 32'd0);
    check("sat_locked", 32'(link_state), 32'd2);

    // Asynchronous reset mid-operation
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_state", 32'(link_state), 32'd0);
    check("arst_rx", 32'(rx_enable), 32'd0);
    check("arst_up", 32'(link_up), 32'd0);
    compare_all();
    @(negedge clk_sys);
    rst_n = 1'b1;
    idle(HOLD);
    check("arst_reacq", 32'(link_state), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_link_ctrl.md
Name: frame_link_ctrl

Overview:
Link supervisor that sequences the 56-bit frame synchronizer on the coax receive path. It consumes the synchronizer's data_valid, frame_error and sync_lost pulses, gates the receive bit stream, and walks the link through reset, acquisition, lock and recovery. It also keeps saturating link statistics for the register interface. It sits between the CDR/frame synchronizer and the downstream data consumer, all in the 100 MHz clk_sys domain.

Parameters:
LOCK_FRAMES, 4, consecutive clean frames required to declare lock (1..255)
UNLOCK_ERRS, 3, consecutive CRC errors in LOCKED that force recovery (1..15)
HOLD_CYCLES, 64, cycles rx_enable is held low in IDLE and RECOVER (1..65535)
TIMEOUT, 4096, cycles without data_valid before the watchdog fires (2..65535)

Ports:
clk_sys  in  1  100 MHz system clock
rst_n  in  1  asynchronous active-low reset
data_valid  in  1  one-cycle pulse: good-CRC frame from the synchronizer
frame_error  in  1  one-cycle pulse: CRC error
sync_lost  in  1  one-cycle pulse: counter discontinuity or 8-error loss
clear_stats  in  1  synchronous pulse: zero all statistics counters
rx_enable  out  1  gates bit_valid into the synchronizer; 0 = hold the receiver idle
link_up  out  1  high only in LOCKED
link_state  out  2  IDLE=00, ACQUIRE=01, LOCKED=10, RECOVER=11
resync_req  out  1  one-cycle pulse on every entry to RECOVER
good_cnt  out  16  saturating count of data_valid pulses
err_cnt  out  16  saturating count of frame_error pulses
loss_cnt  out  8  saturating count of LOCKED->RECOVER transitions

Behaviour:
- Reset (async assert, sync release): state=IDLE, rx_enable=0, link_up=0, resync_req=0, all counters 0, hold/watchdog/run counters 0.
- All outputs are registered. A state change takes effect on the clock edge after the triggering input pulse, and rx_enable/link_up/link_state follow in that same cycle.
- IDLE: hold counter counts every cycle. When it reaches HOLD_CYCLES-1, go to ACQUIRE. rx_enable becomes 1 HOLD_CYCLES cycles after reset release.
- ACQUIRE: rx_enable=1.
  - run counter increments on data_valid with sync_lost=0, and clears on frame_error or sync_lost.
  - When the run reaches LOCK_FRAMES, go to LOCKED; the run counter and the bad counter clear.
  - Watchdog expiry goes to RECOVER. loss_cnt does not increment.
- LOCKED: link_up=1.
  - frame_error increments the bad counter; data_valid clears it.
  - Go to RECOVER when the bad counter reaches UNLOCK_ERRS, on any sync_lost, or on watchdog expiry. loss_cnt increments by 1 on this transition.
- RECOVER: rx_enable=0. resync_req pulses in the first cycle. After HOLD_CYCLES cycles, go to ACQUIRE with the run counter cleared.
- Watchdog: clears on data_valid and on every state entry, and counts in ACQUIRE/LOCKED only. It expires when the count equals TIMEOUT-1.
- Same-cycle data_valid + sync_lost: good_cnt increments. For the state machine the cycle counts as a loss event (run clears in ACQUIRE; LOCKED goes to RECOVER).
- Same-cycle watchdog expiry + data_valid: data_valid wins and the watchdog clears.
- Statistics:
  - good_cnt and err_cnt count in every state; pulses arriving while rx_enable=0 are still counted.
  - All counters saturate at all-ones and never wrap.
  - clear_stats zeroes all three counters. If clear_stats coincides with an increment, clear wins and the result is 0.
- Input pulses in IDLE/RECOVER do not affect state.
- Reset asserted mid-operation returns to IDLE immediately with all reset values, regardless of state.

Test Plan:
- Reset release, no input -> rx_enable=0 for 64 cycles, then link_state=01, rx_enable=1.
- In ACQUIRE, 4 data_valid pulses 56 cycles apart -> link_state=10 and link_up=1 one cycle after the 4th pulse; good_cnt=4.
- In ACQUIRE, 3 good frames, then frame_error, then 4 good frames -> LOCKED only after the 8th pulse overall; err_cnt=1.
- In LOCKED, 3 frame_error pulses -> RECOVER; resync_req high for exactly 1 cycle; loss_cnt=1; rx_enable low 64 cycles; then ACQUIRE.
- In LOCKED, data_valid and sync_lost in the same cycle -> RECOVER; good_cnt increments; loss_cnt increments.
- In LOCKED, no data_valid for 4096 cycles -> RECOVER. Separately, drive good_cnt to 0xFFFF, apply more pulses -> holds 0xFFFF; clear_stats plus a coincident pulse -> 0.
